// File: rtl/axilite_pkg.sv
// Shared types for the AXI4-Lite to APB3 bridge: response codes, FSM states, APB request payload.
package axilite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [1:0] resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WRESP,
    ST_RRESP
  } bridge_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/axilite_chan_capture.sv
// One-deep holding register for an AXI request channel; ready is the registered inverse of full.
module axilite_chan_capture #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid,
  input  logic [W-1:0] data_in,
  input  logic         clear,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] data
);

  logic full_next;

  always_comb begin
    full_next = full;
    if (clear) begin
      full_next = 1'b0;
    end else if (valid && ready) begin
      full_next = 1'b1;
    end
  end

  // ready is held low through reset and tracks !full from the first clock afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b0;
      data  <= '0;
    end else begin
      full  <= full_next;
      ready <= !full_next;
      if (valid && ready && !clear) begin
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/axilite_apb_bridge.sv
// AXI4-Lite responder that serves one captured write or read at a time as a single APB3 transfer.
module axilite_apb_bridge #(
  parameter logic [31:0] ADDR_RANGE = 32'h1000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic [31:0] m_apb_paddr,
  output logic [31:0] m_apb_pwdata,
  output logic        m_apb_psel,
  output logic        m_apb_penable,
  output logic        m_apb_pwrite,
  input  logic [31:0] m_apb_prdata,
  input  logic        m_apb_pready,
  input  logic        m_apb_pslverr
);

  import axilite_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  bridge_state_t     state;
  logic              prio_wr;
  logic              is_write;
  logic [CNT_W-1:0]  wait_cnt;

  logic              aw_full;
  logic              w_full;
  logic              ar_full;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] ar_addr;

  logic              wr_elig;
  logic              rd_elig;
  logic              pick_wr;
  logic              sel_decerr;
  logic              timeout_hit;
  logic              wr_done;
  logic              rd_done;
  apb_req_t          sel_req;

  axilite_chan_capture #(.W(ADDR_W)) u_aw (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .valid   (s_axi_awvalid),
    .data_in (s_axi_awaddr),
    .clear   (wr_done),
    .ready   (s_axi_awready),
    .full    (aw_full),
    .data    (aw_addr)
  );

  axilite_chan_capture #(.W(DATA_W)) u_w (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .valid   (s_axi_wvalid),
    .data_in (s_axi_wdata),
    .clear   (wr_done),
    .ready   (s_axi_wready),
    .full    (w_full),
    .data    (w_data)
  );

  axilite_chan_capture #(.W(ADDR_W)) u_ar (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .valid   (s_axi_arvalid),
    .data_in (s_axi_araddr),
    .clear   (rd_done),
    .ready   (s_axi_arready),
    .full    (ar_full),
    .data    (ar_addr)
  );

  // Arbitration: prio_wr only matters, and only flips, when both kinds are eligible together
  always_comb begin
    wr_elig       = aw_full && w_full;
    rd_elig       = ar_full;
    pick_wr       = wr_elig && (!rd_elig || prio_wr);
    sel_req.write = pick_wr;
    sel_req.addr  = pick_wr ? aw_addr : ar_addr;
    sel_req.wdata = pick_wr ? w_data : '0;
    sel_decerr    = (sel_req.addr >= ADDR_RANGE);
    timeout_hit   = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == TIMEOUT);
    wr_done       = s_axi_bvalid && s_axi_bready;
    rd_done       = s_axi_rvalid && s_axi_rready;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= ST_IDLE;
      prio_wr       <= 1'b1;
      is_write      <= 1'b0;
      wait_cnt      <= '0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_elig || rd_elig) begin
            if (wr_elig && rd_elig) begin
              prio_wr <= !prio_wr;
            end
            is_write <= pick_wr;
            if (sel_decerr) begin
              if (pick_wr) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= DECERR;
                state        <= ST_WRESP;
              end else begin
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= DECERR;
                s_axi_rdata  <= '0;
                state        <= ST_RRESP;
              end
            end else begin
              m_apb_paddr  <= sel_req.addr;
              m_apb_pwdata <= sel_req.wdata;
              m_apb_pwrite <= sel_req.write;
              m_apb_psel   <= 1'b1;
              wait_cnt     <= '0;
              state        <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          m_apb_penable <= 1'b1;
          state         <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (m_apb_pready || timeout_hit) begin
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            if (is_write) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (!m_apb_pready || m_apb_pslverr) ? SLVERR : OKAY;
              state        <= ST_WRESP;
            end else begin
              s_axi_rvalid <= 1'b1;
              s_axi_rresp  <= (!m_apb_pready || m_apb_pslverr) ? SLVERR : OKAY;
              s_axi_rdata  <= (!m_apb_pready || m_apb_pslverr) ? '0 : m_apb_prdata;
              state        <= ST_RRESP;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WRESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_apb_bridge.sv
// Randomized bench for axilite_apb_bridge: APB responder, transaction-level reference model, directed corner cases.
module tb_axilite_apb_bridge;

  localparam logic [31:0] RANGE = 32'h1000;
  localparam int          TO    = 16;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] sa;
    logic [31:0] d;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int          total = 0;
  int          bad = 0;
  xfer_t       apb_log[$];
  int          apb_waits = 0;
  bit          apb_err = 1'b0;
  logic [31:0] apb_rdata = '0;
  int          pen_cycles = 0;
  int          acc_cnt = 0;
  logic [31:0] setup_addr = '0;
  bit          model_prio_wr = 1'b1;

  axilite_apb_bridge #(.ADDR_RANGE(RANGE), .TIMEOUT(TO)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .m_apb_paddr   (paddr),
    .m_apb_pwdata  (pwdata),
    .m_apb_psel    (psel),
    .m_apb_penable (penable),
    .m_apb_pwrite  (pwrite),
    .m_apb_prdata  (prdata),
    .m_apb_pready  (pready),
    .m_apb_pslverr (pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // APB peripheral: completes after apb_waits wait states, logs every completed transfer
  always @(negedge clk) begin
    if (psel && !penable) setup_addr = paddr;
    if (psel && penable) begin
      pen_cycles++;
      if (acc_cnt >= apb_waits) begin
        pready  = 1'b1;
        pslverr = apb_err;
        prdata  = apb_rdata;
        apb_log.push_back('{w: pwrite, a: paddr, sa: setup_addr, d: pwdata});
      end else begin
        pready  = 1'b0;
        pslverr = apb_err;
        prdata  = $urandom;
      end
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      acc_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level outcome: response, read data, first-valid cycle, ACCESS cycles, completed transfers
  function automatic void model(input logic [31:0] a, input int waits, input bit err,
                                input logic [31:0] rd, output logic [1:0] resp,
                                output logic [31:0] data, output int lat, output int accs,
                                output int xfers);
    if (a >= RANGE) begin
      resp = 2'b11; data = '0; lat = 2; accs = 0; xfers = 0;
    end else if (waits >= TO) begin
      resp = 2'b10; data = '0; accs = TO; lat = 3 + TO; xfers = 0;
    end else begin
      resp  = err ? 2'b10 : 2'b00;
      data  = err ? 32'h0 : rd;
      accs  = waits + 1;
      lat   = 3 + accs;
      xfers = 1;
    end
  endfunction

  task automatic wait_for(input bit want_b, output int n);
    n = 1;
    while (!(want_b ? bvalid : rvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(want_b ? "bvalid_seen" : "rvalid_seen", 32'(want_b ? bvalid : rvalid), 32'd1);
  endtask

  task automatic finish_b(input int hold, input logic [1:0] er);
    check("bresp", 32'(bresp), 32'(er));
    repeat (hold) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
      check("bresp_held", 32'(bresp), 32'(er));
      check("psel_idle_b", 32'(psel), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic finish_r(input int hold, input logic [1:0] er, input logic [31:0] ed);
    check("rresp", 32'(rresp), 32'(er));
    check("rdata", rdata, ed);
    repeat (hold) begin
      @(negedge clk);
      check("rvalid_held", 32'(rvalid), 32'd1);
      check("rdata_held", rdata, ed);
      check("psel_idle_r", 32'(psel), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  task automatic check_xfer(input int base, input int cnt, input bit w,
                            input logic [31:0] a, input logic [31:0] d);
    check("apb_count", 32'(apb_log.size() - base), 32'(cnt));
    if (cnt == 1 && apb_log.size() > base) begin
      check("pwrite", 32'(apb_log[base].w), 32'(w));
      check("paddr", apb_log[base].a, a);
      check("paddr_setup", apb_log[base].sa, a);
      if (w) check("pwdata", apb_log[base].d, d);
    end
  endtask

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW first
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lead,
                          input int waits, input bit err, input int hold);
    logic [1:0]  er;
    logic [31:0] ed;
    int el, ea, ex, n, base, span, aw_at, w_at;
    model(a, waits, err, 32'h0, er, ed, el, ea, ex);
    apb_waits = waits; apb_err = err; pen_cycles = 0; base = apb_log.size();
    span  = (lead < 0) ? -lead : lead;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    for (int t = 0; t <= span; t++) begin
      @(negedge clk);
      if (t == aw_at) begin
        check("awready", 32'(awready), 32'd1);
        awvalid = 1'b1; awaddr = a;
      end else awvalid = 1'b0;
      if (t == w_at) begin
        check("wready", 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = d;
      end else wvalid = 1'b0;
      if (span > 0 && t == span)
        check(lead > 0 ? "wready_full" : "awready_full", 32'(lead > 0 ? wready : awready), 32'd0);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_for(1'b1, n);
    check("b_latency", 32'(n), 32'(el));
    check("pen_cycles_w", 32'(pen_cycles), 32'(ea));
    finish_b(hold, er);
    check_xfer(base, ex, 1'b1, a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input int waits, input bit err,
                         input logic [31:0] rd, input int hold);
    logic [1:0]  er;
    logic [31:0] ed;
    int el, ea, ex, n, base;
    model(a, waits, err, rd, er, ed, el, ea, ex);
    apb_waits = waits; apb_err = err; apb_rdata = rd; pen_cycles = 0; base = apb_log.size();
    @(negedge clk);
    check("arready", 32'(arready), 32'd1);
    arvalid = 1'b1; araddr = a;
    @(negedge clk);
    arvalid = 1'b0;
    wait_for(1'b0, n);
    check("r_latency", 32'(n), 32'(el));
    check("pen_cycles_r", 32'(pen_cycles), 32'(ea));
    finish_r(hold, er, ed);
    check_xfer(base, ex, 1'b0, a, 32'h0);
  endtask

  // AW, W and AR all in one cycle; the model expects alternation between rounds
  task automatic do_both(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                         input logic [31:0] rd, input int hold);
    int n, base;
    bit first_wr;
    apb_waits = 0; apb_err = 1'b0; apb_rdata = rd; base = apb_log.size();
    first_wr = model_prio_wr;
    @(negedge clk);
    awvalid = 1'b1; awaddr = wa; wvalid = 1'b1; wdata = wd; arvalid = 1'b1; araddr = ra;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 1;
    while (!bvalid && !rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("arb_first", 32'(bvalid), 32'(first_wr));
    check("arb_latency", 32'(n), 32'd4);
    if (first_wr) begin
      finish_b(hold, 2'b00);
      wait_for(1'b0, n);
      finish_r(0, 2'b00, rd);
    end else begin
      finish_r(hold, 2'b00, rd);
      wait_for(1'b1, n);
      finish_b(0, 2'b00);
    end
    check("both_count", 32'(apb_log.size() - base), 32'd2);
    if (apb_log.size() >= base + 2) begin
      check("first_dir", 32'(apb_log[base].w), 32'(first_wr));
      check("second_dir", 32'(apb_log[base + 1].w), 32'(!first_wr));
      check("first_pwdata", first_wr ? apb_log[base].d : apb_log[base + 1].d, wd);
    end
    model_prio_wr = !model_prio_wr;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          waits, lead, hold, r, n;
    bit          err, is_wr;

    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({awready, wready, arready, bvalid, rvalid, psel, penable, pwrite, bresp, rresp}), 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_write(32'h10, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    do_write(32'h14, 32'hA5A5A5A5, 3, 0, 1'b0, 0);
    do_read(32'h20, 2, 1'b0, 32'h12345678, 0);
    do_write(32'h1000, 32'h0BADF00D, 0, 0, 1'b0, 0);
    do_read(32'h8, 0, 1'b1, 32'hCAFEF00D, 0);
    do_read(32'h4, 1000, 1'b0, 32'h13572468, 0);
    do_both(32'h30, 32'h11112222, 32'h34, 32'h33334444, 5);
    do_both(32'h38, 32'h55556666, 32'h3C, 32'h77778888, 2);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = RANGE;
      else if (r == 1) a = $urandom | 32'h8000_0000;
      else if (r == 2) a = RANGE - 32'd4;
      else             a = 32'($urandom_range(0, 1023)) << 2;
      r     = int'($urandom_range(0, 9));
      waits = (r == 9) ? 1000 : r % 4;
      err   = ($urandom_range(0, 3) == 0);
      lead  = int'($urandom_range(0, 4)) - 2;
      hold  = int'($urandom_range(0, 2));
      d     = $urandom;
      is_wr = ($urandom_range(0, 1) == 1);
      if (is_wr) do_write(a, d, lead, waits, err, hold);
      else       do_read(a, waits, err, d, hold);
    end

    apb_waits = 1000; apb_err = 1'b0; pen_cycles = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h40;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_penable", 32'(penable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({awready, wready, arready, bvalid, rvalid, psel, penable, pwrite, bresp, rresp}), 32'd0);
    check("midrst_paddr", paddr, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_prio_wr = 1'b1;
    repeat (3) @(negedge clk);
    check("no_resp_after_rst", 32'({rvalid, bvalid, psel}), 32'd0);
    check("arready_after_rst", 32'(arready), 32'd1);
    do_both(32'h50, 32'h9ABCDEF0, 32'h54, 32'h0F0F0F0F, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
